float_recip_pipe: RTL and testbench

FLOAT_RECIP_PIPE -- requirements
Module: float_recip_pipe

---
 rtl/float_recip_pipe_pkg.sv | 49 ++++
 rtl/float_recip_pipe_recip.sv | 84 ++++++++
 rtl/float_recip_pipe.sv | 99 +++++++++
 tb/tb_float_recip_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_recip_pipe_pkg.sv
// Shared binary32 definitions for the reciprocal pipeline.
//   - field widths, exponent bias, all-ones exponent and canonical quiet NaN
//   - mantissa core width MS (S1.23 fixed point)
//   - recip_lat(): end-to-end latency for a given Newton-Raphson count
//   - side-band record carried alongside the mantissa core, and its builder
package float_recip_pipe_pkg;

    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;
    localparam logic [EXP_W-1:0] EXP_ONES = 8'd255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int unsigned MS = 25;

    function automatic int unsigned recip_lat(input int unsigned itr);
        return 6 + 3 * itr;
    endfunction

    typedef enum logic [1:0] {
        CLS_FINITE,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fcls_t;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic             mzero;
        fcls_t            cls;
    } sideband_t;

    // Zero and denormal inputs share CLS_ZERO (denormals flushed on input).
    function automatic sideband_t unpack_side(input logic [31:0] x);
        sideband_t sb;
        sb.s     = x[31];
        sb.e     = x[30:23];
        sb.mzero = (x[22:0] == '0);
        if (sb.e == '0)
            sb.cls = CLS_ZERO;
        else if (sb.e == EXP_ONES)
            sb.cls = sb.mzero ? CLS_INF : CLS_NAN;
        else
            sb.cls = CLS_FINITE;
        return sb;
    endfunction

endpackage

// File: rtl/float_recip_pipe_recip.sv
// ComputeRecip: pipelined mantissa reciprocal.
//   clk : clock
//   d   : divisor in S1.MS-2 fixed point, value in [1,2)
//   r   : 1/d in S1.MS-2 fixed point, truncated, valid 4+3*ITR cycles after d
// Seed from a 64-entry table (midpoint reciprocals, ~2^-7 relative error),
// then ITR Newton-Raphson steps x' = x*(2 - d*x), three registers per step.
// Datapath only: no reset, no valid; the caller tracks validity.
module ComputeRecip #(
    parameter int unsigned MS  = 25,
    parameter int unsigned ITR = 2
) (
    input  logic          clk,
    input  logic [MS-1:0] d,
    output logic [MS-1:0] r
);

    localparam int unsigned FB    = 30;           // working fraction bits
    localparam int unsigned XW    = FB + 1;       // x: Q1.FB
    localparam int unsigned FW    = FB + 2;       // d*x and 2-d*x: Q2.FB
    localparam int unsigned DW    = MS - 1;       // d without sign bit
    localparam int unsigned DF    = MS - 2;       // fraction bits of d
    localparam int unsigned PW    = DW + XW;
    localparam int unsigned QW    = XW + FW;
    localparam int unsigned LB    = 6;
    localparam int unsigned LUT_N = 1 << LB;
    localparam int unsigned NS    = (ITR > 0) ? ITR : 1;
    localparam logic [FW-1:0] TWO = FW'(1) << (FB + 1);

    typedef logic [XW-1:0] lut_t [LUT_N];

    // Entry k holds 1/(1 + (2k+1)/(2*LUT_N)) in Q1.FB.
    function automatic lut_t build_lut();
        lut_t t;
        for (int unsigned k = 0; k < LUT_N; k++)
            t[k] = XW'((64'd1 << (FB + LB + 1)) / 64'(2 * LUT_N + 2 * k + 1));
        return t;
    endfunction

    localparam lut_t LUT = build_lut();

    logic [DW-1:0] d_q;
    logic [DW-1:0] d_ch [ITR+1];
    logic [XW-1:0] x_ch [ITR+1];
    logic [DW-1:0] d_a  [NS];
    logic [XW-1:0] x_a  [NS];
    logic [FW-1:0] p_a  [NS];
    logic [DW-1:0] d_b  [NS];
    logic [XW-1:0] x_b  [NS];
    logic [FW-1:0] e_b  [NS];
    logic [FW-1:0] p_c  [NS];
    logic [XW-1:0] x_n  [NS];
    logic [MS-1:0] r_q;

    always_comb begin
        p_c = '{default: '0};
        x_n = '{default: '0};
        for (int unsigned i = 0; i < ITR; i++) begin
            p_c[i] = FW'((PW'(d_ch[i]) * PW'(x_ch[i])) >> DF);
            x_n[i] = XW'((QW'(x_b[i]) * QW'(e_b[i])) >> FB);
        end
    end

    always_ff @(posedge clk) begin
        d_q     <= d[DW-1:0];
        d_ch[0] <= d_q;
        x_ch[0] <= LUT[d_q[DF-1 -: LB]];
        for (int unsigned i = 0; i < ITR; i++) begin
            d_a[i]    <= d_ch[i];
            x_a[i]    <= x_ch[i];
            p_a[i]    <= p_c[i];
            d_b[i]    <= d_a[i];
            x_b[i]    <= x_a[i];
            e_b[i]    <= TWO - p_a[i];
            d_ch[i+1] <= d_b[i];
            x_ch[i+1] <= x_n[i];
        end
        r_q <= {1'b0, x_ch[ITR][FB -: DW]};
        r   <= r_q;
    end

    logic unused_bits;
    assign unused_bits = ^{d[MS-1], d_ch[ITR], x_ch[ITR][FB-DW:0]};

endmodule

// File: rtl/float_recip_pipe.sv
// float_recip_pipe: streaming binary32 reciprocal, one operand per cycle.
//   clk     : clock
//   reset   : synchronous active-high reset, clears all valid state
//   s_valid : operand valid
//   s_data  : binary32 operand x
//   m_valid : result valid, 6+3*ITR cycles after the operand
//   m_data  : binary32 approximation of 1/x, held while m_valid=0
// Unpack register -> ComputeRecip (4+3*ITR) -> normalise/pack register.
module float_recip_pipe
    import float_recip_pipe_pkg::*;
#(
    parameter int unsigned ITR = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        m_valid,
    output logic [31:0] m_data
);

    localparam int unsigned CORE_LAT = recip_lat(ITR) - 2;

    logic                u_valid;
    sideband_t           u_sb;
    logic [MS-1:0]       u_d;
    logic [MS-1:0]       core_r;
    sideband_t           sb_pipe [CORE_LAT];
    logic [CORE_LAT-1:0] v_pipe;

    sideband_t          sb;
    logic signed [9:0]  e_norm;
    logic signed [9:0]  e_exact;
    logic [31:0]        result;

    ComputeRecip #(
        .MS  (MS),
        .ITR (ITR)
    ) u_recip (
        .clk (clk),
        .d   (u_d),
        .r   (core_r)
    );

    // Valid tracking: only this path is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            u_valid <= 1'b0;
            v_pipe  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            u_valid <= s_valid;
            v_pipe  <= {v_pipe[CORE_LAT-2:0], u_valid};
            m_valid <= v_pipe[CORE_LAT-1];
            if (v_pipe[CORE_LAT-1])
                m_data <= result;
        end
    end

    always_ff @(posedge clk) begin
        u_d        <= {1'b0, 1'b1, s_data[MAN_W-1:0]};
        u_sb       <= unpack_side(s_data);
        sb_pipe[0] <= u_sb;
        for (int unsigned i = 1; i < CORE_LAT; i++)
            sb_pipe[i] <= sb_pipe[i-1];
    end

    // Core result lies in (0.5,1): bit MS-3 is the leading one, so the
    // stored mantissa is the next MS-3 bits with a zero appended.
    always_comb begin
        sb      = sb_pipe[CORE_LAT-1];
        e_norm  = signed'(10'(2 * EXP_BIAS - 1)) - signed'({2'b00, sb.e});
        e_exact = signed'(10'(2 * EXP_BIAS))     - signed'({2'b00, sb.e});
        result  = '0;
        unique case (sb.cls)
            CLS_NAN:  result = QNAN;
            CLS_INF:  result = {sb.s, 31'b0};
            CLS_ZERO: result = {sb.s, EXP_ONES, 23'b0};
            default: begin
                if (sb.mzero) begin
                    if (e_exact <= 10'sd0)
                        result = {sb.s, 31'b0};
                    else
                        result = {sb.s, e_exact[7:0], 23'b0};
                end else begin
                    if (e_norm <= 10'sd0)
                        result = {sb.s, 31'b0};
                    else
                        result = {sb.s, e_norm[7:0], core_r[MS-4:0], 1'b0};
                end
            end
        endcase
    end

    logic unused_core;
    assign unused_core = ^core_r[MS-1:MS-3];

endmodule

// File: tb/tb_float_recip_pipe.sv
// Self-checking bench for float_recip_pipe (ITR=2, latency 12).
module tb_float_recip_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_data;
    logic        m_valid;
    logic [31:0] m_data;

    int total = 0;
    int bad   = 0;

    float_recip_pipe #(.ITR(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one operand, then watch 30 cycles for its result.
    task automatic run_one(input logic [31:0] x, output logic [31:0] y, output int lat);
        s_valid = 1'b1;
        s_data  = x;
        lat = -1;
        y   = '0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) s_valid = 1'b0;
            if (m_valid === 1'b1 && lat < 0) begin
                lat = k;
                y   = m_data;
            end
        end
    endtask

    // Independent reference: exact integer division, round to nearest.
    function automatic logic [31:0] model(input logic [31:0] x, output bit exact);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        int          ev;
        logic [63:0] mi, q2, rnd;
        s = x[31]; e = x[30:23]; m = x[22:0];
        exact = 1'b1;
        if (e == 8'd0) return {s, 8'hFF, 23'h0};
        if (e == 8'hFF) return (m == 23'h0) ? {s, 31'h0} : 32'h7FC00000;
        if (m == 23'h0) begin
            ev = 254 - int'(e);
            return (ev <= 0) ? {s, 31'h0} : {s, ev[7:0], 23'h0};
        end
        ev = 253 - int'(e);
        if (ev <= 0) return {s, 31'h0};
        exact = 1'b0;
        mi  = 64'h80_0000 | 64'(m);
        q2  = (64'd1 << 48) / mi;
        rnd = (q2 + 64'd1) >> 1;
        return {s, ev[7:0], rnd[22:0]};
    endfunction

    task automatic test_reset();
        bit seen;
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h40000000;
        repeat (3) tick();
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        total++;
        if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data: got %h expected 00000000", m_data); end
        reset   = 1'b0;
        s_valid = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (m_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_no_output: got %b expected 0", seen); end
    endtask

    task automatic test_latency();
        logic        mv [14];
        logic [31:0] md [14];
        s_valid = 1'b1;
        s_data  = 32'h40000000;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) s_valid = 1'b0;
            mv[k] = m_valid;
            md[k] = m_data;
        end
        total++;
        if (mv[11] !== 1'b0) begin bad++; $display("FAIL lat_t11: got %b expected 0", mv[11]); end
        total++;
        if (mv[12] !== 1'b1) begin bad++; $display("FAIL lat_t12: got %b expected 1", mv[12]); end
        total++;
        if (md[12] !== 32'h3F000000) begin bad++; $display("FAIL lat_data: got %h expected 3f000000", md[12]); end
        total++;
        if (mv[13] !== 1'b0) begin bad++; $display("FAIL lat_t13: got %b expected 0", mv[13]); end
        total++;
        if (md[13] !== 32'h3F000000) begin bad++; $display("FAIL hold_data: got %h expected 3f000000", md[13]); end
    endtask

    task automatic test_normal();
        logic [31:0] vin [4] = '{32'h40400000, 32'hC0800000, 32'h3FC00000, 32'h3F400000};
        logic [31:0] vex [4] = '{32'h3EAAAAAB, 32'hBE800000, 32'h3F2AAAAB, 32'h3FAAAAAB};
        int          vtol[4] = '{4, 0, 4, 4};
        logic [31:0] y;
        int lat, d;
        for (int i = 0; i < 4; i++) begin
            run_one(vin[i], y, lat);
            total++;
            if (lat != 12) begin bad++; $display("FAIL normal_lat[%0d]: got %0d expected 12", i, lat); end
            d = int'({1'b0, y[30:0]}) - int'({1'b0, vex[i][30:0]});
            if (d < 0) d = -d;
            total++;
            if (y[31] !== vex[i][31] || d > vtol[i] || $isunknown(y)) begin
                bad++;
                $display("FAIL normal[%0d] in=%h: got %h expected %h within %0d ulp", i, vin[i], y, vex[i], vtol[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] vin [7] = '{32'h00000000, 32'h80000001, 32'hFF800000, 32'h7FC00001,
                                 32'hFFFFFFFF, 32'h7F800000, 32'h00400000};
        logic [31:0] vex [7] = '{32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7FC00000,
                                 32'h7FC00000, 32'h00000000, 32'h7F800000};
        logic [31:0] y;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_one(vin[i], y, lat);
            total++;
            if (lat != 12 || y !== vex[i]) begin
                bad++;
                $display("FAIL special[%0d] in=%h: got %h (lat %0d) expected %h (lat 12)", i, vin[i], y, lat, vex[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] vin [4] = '{32'h7E800000, 32'h7F000000, 32'h7EC00000, 32'h00800000};
        logic [31:0] vex [4] = '{32'h00800000, 32'h00000000, 32'h00000000, 32'h7E800000};
        logic [31:0] y;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_one(vin[i], y, lat);
            total++;
            if (lat != 12 || y !== vex[i]) begin
                bad++;
                $display("FAIL boundary[%0d] in=%h: got %h (lat %0d) expected %h (lat 12)", i, vin[i], y, lat, vex[i]);
            end
        end
    endtask

    // Powers of two with exponent field 100+i: result exponent 154-i, exact.
    task automatic test_stream();
        bit          pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bit          in_hist [128];
        logic [7:0]  idx;
        logic [31:0] want;
        int sent = 0;
        int got  = 0;
        bit v, expv;
        for (int c = 0; c < 80; c++) begin
            v = (sent < 20) && pat[c % 6];
            in_hist[c] = v;
            s_valid = v;
            idx = 8'(sent);
            s_data = v ? {idx[0], 8'(100 + sent), 23'h0} : 32'hDEADBEEF;
            if (v) sent++;
            tick();
            expv = (c >= 11) ? in_hist[c-11] : 1'b0;
            total++;
            if (m_valid !== expv) begin bad++; $display("FAIL stream_gap c=%0d: got %b expected %b", c, m_valid, expv); end
            if (m_valid === 1'b1) begin
                idx  = 8'(got);
                want = {idx[0], 8'(154 - got), 23'h0};
                total++;
                if (m_data !== want) begin bad++; $display("FAIL stream_data[%0d]: got %h expected %h", got, m_data, want); end
                got++;
            end
        end
        s_valid = 1'b0;
        total++;
        if (got != 20) begin bad++; $display("FAIL stream_count: got %0d expected 20", got); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] y;
        int lat;
        bit seen;
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1;
            s_data  = 32'h40000000;
            tick();
        end
        reset   = 1'b1;
        s_data  = 32'h40400000;
        tick();
        reset   = 1'b0;
        s_valid = 1'b0;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL midreset_m_valid: got %b expected 0", m_valid); end
        total++;
        if (m_data !== 32'h0) begin bad++; $display("FAIL midreset_m_data: got %h expected 00000000", m_data); end
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (m_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midreset_leak: got %b expected 0", seen); end
        run_one(32'h41000000, y, lat);
        total++;
        if (lat != 12 || y !== 32'h3E000000) begin
            bad++; $display("FAIL post_reset_a: got %h (lat %0d) expected 3e000000 (lat 12)", y, lat);
        end
        run_one(32'hBF000000, y, lat);
        total++;
        if (lat != 12 || y !== 32'hC0000000) begin
            bad++; $display("FAIL post_reset_b: got %h (lat %0d) expected c0000000 (lat 12)", y, lat);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 10000;
        logic [31:0] exp_q [$];
        bit          ex_q  [$];
        logic [31:0] sp [7] = '{32'h00000000, 32'h80000001, 32'hFF800000, 32'h7FC00001,
                                32'hFFFFFFFF, 32'h7F800000, 32'h3F800000};
        logic [31:0] x, want;
        bit ex, fail;
        int d;
        for (int c = 0; c < N + 40; c++) begin
            if (c < N) begin
                if (c % 8 == 7)
                    x = sp[$urandom_range(0, 6)];
                else
                    x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
                want = model(x, ex);
                exp_q.push_back(want);
                ex_q.push_back(ex);
                s_valid = 1'b1;
                s_data  = x;
            end else begin
                s_valid = 1'b0;
            end
            tick();
            if (m_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got %h expected no result", m_data);
                end else begin
                    want = exp_q.pop_front();
                    ex   = ex_q.pop_front();
                    d = int'({1'b0, m_data[30:0]}) - int'({1'b0, want[30:0]});
                    if (d < 0) d = -d;
                    fail = ex ? (m_data !== want)
                              : (m_data[31] !== want[31] || d > 4 || $isunknown(m_data));
                    if (fail) begin
                        bad++; $display("FAIL b2b: got %h expected %h (exact=%0d)", m_data, want, ex);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        test_reset();
        test_latency();
        test_normal();
        test_specials();
        test_boundaries();
        test_stream();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
